cdc_hs_rx_ctrl: RTL and testbench

Destination-side controller for a four-phase request/acknowledge clock-domain crossing. It synchronizes an asynchronous request level through an internal flop chain and captures a multi-bit bundle that the source holds stable. It presents the bundle downstream with valid/ready and returns an acknowledge level to the source domain. It sits at the receive end of every multi-bit crossing that the single-bit synchronizer alone cannot carry.

---
 rtl/cdc_pkg.sv | 6 +
 rtl/cdc_sync_n.sv | 16 +
 rtl/cdc_hs_rx_ctrl.sv | 74 +++++++
 tb/tb_cdc_hs_rx_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// cdc_pkg: shared state encoding and default constants for the CDC handshake receiver.
package cdc_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, ACK = 2'd2} cdc_state_e;
  localparam int CDC_SYNC_STAGES_DEF = 2;
  localparam int CDC_TIMEOUT_DEF = 1024;
endpackage

// File: rtl/cdc_sync_n.sv
// cdc_sync_n: SYNC_STAGES-deep flop chain synchronizing one asynchronous level.
module cdc_sync_n #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] chain;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) chain <= '0;
    else chain <= {chain[SYNC_STAGES-2:0], d};
  end
  assign q = chain[SYNC_STAGES-1];
endmodule

// File: rtl/cdc_hs_rx_ctrl.sv
// cdc_hs_rx_ctrl: four-phase req/ack receive controller presenting the captured bundle via valid/ready.
// Optional sticky acknowledge-phase timeout enabled by CDC_HS_RX_TIMEOUT_EN.
module cdc_hs_rx_ctrl
  import cdc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = CDC_SYNC_STAGES_DEF
`ifdef CDC_HS_RX_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = CDC_TIMEOUT_DEF
`endif
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_async,
  input  logic [WIDTH-1:0] data_async,
  output logic             ack,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
`ifdef CDC_HS_RX_TIMEOUT_EN
  output logic             timeout_err,
`endif
  input  logic             data_ready
);
  cdc_state_e state, next_state;
  logic req_s, capture, ack_d, valid_d;

  cdc_sync_n #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .clock(clock), .reset_n(reset_n), .d(req_async), .q(req_s)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ack        <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
    end else begin
      state      <= next_state;
      ack        <= ack_d;
      data_valid <= valid_d;
      if (capture) data_out <= data_async;
    end
  end

  always_comb begin
    next_state = (state == IDLE) ? (req_s ? HOLD : IDLE) :
                 (state == HOLD) ? (data_ready ? ACK : HOLD) :
                 (state == ACK)  ? (req_s ? ACK : IDLE) : IDLE;
  end

  // ack and data_valid are registered straight from the next state so the source sees a clean level
  always_comb begin
    capture = (state == IDLE) && req_s;
    ack_d   = (next_state == ACK);
    valid_d = (next_state == HOLD);
  end

`ifdef CDC_HS_RX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0] to_cnt;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else if (state != ACK) begin
      to_cnt <= '0;
    end else if (req_s && to_cnt != TMAX) begin
      to_cnt <= to_cnt + 1'b1;
      if (to_cnt == TMAX - 1'b1) timeout_err <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_cdc_hs_rx_ctrl.sv
// tb_cdc_hs_rx_ctrl: directed self-checking bench for cdc_hs_rx_ctrl (timeout case under CDC_HS_RX_TIMEOUT_EN).
module tb_cdc_hs_rx_ctrl;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic req_async = 1'b0;
  logic [7:0] data_async = 8'h00;
  logic data_ready = 1'b0;
  logic ack, data_valid;
  logic [7:0] data_out;
  int checks = 0;
  int failures = 0;
  int pulses;
`ifdef CDC_HS_RX_TIMEOUT_EN
  logic timeout_err;
`endif

  always #5 clock = ~clock;

`ifdef CDC_HS_RX_TIMEOUT_EN
  cdc_hs_rx_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset_n(reset_n), .req_async(req_async), .data_async(data_async),
    .ack(ack), .data_out(data_out), .data_valid(data_valid), .timeout_err(timeout_err),
    .data_ready(data_ready));
`else
  cdc_hs_rx_ctrl #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset_n(reset_n), .req_async(req_async), .data_async(data_async),
    .ack(ack), .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready));
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drop_req(input string tag);
    req_async = 1'b0;
    step(2);
    chk({tag, "_ack_still_high"}, 32'(ack), 32'd1);
    step(1);
    chk({tag, "_ack_low_edge3"}, 32'(ack), 32'd0);
  endtask

  initial begin
    step(2);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
`ifdef CDC_HS_RX_TIMEOUT_EN
    chk("rst_timeout", 32'(timeout_err), 32'd0);
`endif
    reset_n = 1'b1;
    step(1);
    // basic transfer, ready tied high
    data_ready = 1'b1;
    data_async = 8'hA5;
    req_async = 1'b1;
    step(2);
    chk("t1_valid_edge2", 32'(data_valid), 32'd0);
    step(1);
    chk("t1_valid_edge3", 32'(data_valid), 32'd1);
    chk("t1_data", 32'(data_out), 32'hA5);
    chk("t1_ack_edge3", 32'(ack), 32'd0);
    step(1);
    chk("t1_valid_edge4", 32'(data_valid), 32'd0);
    chk("t1_ack_edge4", 32'(ack), 32'd1);
    drop_req("t1");
    // backpressure
    data_ready = 1'b0;
    data_async = 8'h3C;
    req_async = 1'b1;
    step(3);
    chk("t2_valid", 32'(data_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("t2_hold_valid", 32'(data_valid), 32'd1);
      chk("t2_hold_data", 32'(data_out), 32'h3C);
      chk("t2_hold_ack", 32'(ack), 32'd0);
    end
    data_ready = 1'b1;
    step(1);
    chk("t2_ack_on_accept", 32'(ack), 32'd1);
    chk("t2_valid_cleared", 32'(data_valid), 32'd0);
    chk("t2_data_kept", 32'(data_out), 32'h3C);
    drop_req("t2");
    // req held high across ACK: no recapture
    data_async = 8'h5A;
    req_async = 1'b1;
    step(4);
    chk("t3_ack", 32'(ack), 32'd1);
    data_async = 8'h77;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (data_valid) pulses++;
      chk("t3_ack_held", 32'(ack), 32'd1);
    end
    chk("t3_no_recapture", 32'(pulses), 32'd0);
    chk("t3_data_kept", 32'(data_out), 32'h5A);
    drop_req("t3");
    data_async = 8'h11;
    req_async = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (data_valid) pulses++;
    end
    chk("t3_one_capture", 32'(pulses), 32'd1);
    chk("t3_data_11", 32'(data_out), 32'h11);
    drop_req("t3b");
    // asynchronous reset in HOLD
    data_ready = 1'b0;
    data_async = 8'hC3;
    req_async = 1'b1;
    step(3);
    chk("t4_valid_before", 32'(data_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t4_async_valid", 32'(data_valid), 32'd0);
    chk("t4_async_data", 32'(data_out), 32'd0);
    chk("t4_async_ack", 32'(ack), 32'd0);
    step(1);
    reset_n = 1'b1;
    step(2);
    chk("t4_valid_edge2", 32'(data_valid), 32'd0);
    step(1);
    chk("t4_valid_edge3", 32'(data_valid), 32'd1);
    chk("t4_recapture", 32'(data_out), 32'hC3);
    data_ready = 1'b1;
    step(1);
    chk("t4_ack", 32'(ack), 32'd1);
    drop_req("t4");
    // back-to-back transfers
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      data_async = 8'(k);
      req_async = 1'b1;
      for (int j = 0; j < 3; j++) begin
        step(1);
        if (data_valid) pulses++;
      end
      chk("t5_valid", 32'(data_valid), 32'd1);
      chk("t5_data", 32'(data_out), 32'(k));
      step(1);
      if (data_valid) pulses++;
      chk("t5_ack", 32'(ack), 32'd1);
      drop_req("t5");
    end
    chk("t5_pulse_count", 32'(pulses), 32'd8);
`ifdef CDC_HS_RX_TIMEOUT_EN
    data_async = 8'hE7;
    req_async = 1'b1;
    step(4);
    chk("t6_ack", 32'(ack), 32'd1);
    for (int i = 1; i <= 15; i++) begin
      step(1);
      chk("t6_no_timeout_yet", 32'(timeout_err), 32'd0);
    end
    step(1);
    chk("t6_timeout", 32'(timeout_err), 32'd1);
    chk("t6_ack_stays", 32'(ack), 32'd1);
    drop_req("t6");
    chk("t6_sticky", 32'(timeout_err), 32'd1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
